// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
//   Shared definitions for the registered ALU (alu_seq) and its iterative
//   multiplier (mul_iter).
//   - OP_* : 3-bit cntrl encodings, unchanged from the combinational ALU.
//   - alu_state_t : control FSM states of alu_seq.
// -----------------------------------------------------------------------------
package alu_pkg;

   localparam logic [2:0] OP_PASSB = 3'b000;
   localparam logic [2:0] OP_LSL   = 3'b001;
   localparam logic [2:0] OP_ADD   = 3'b010;
   localparam logic [2:0] OP_SUB   = 3'b011;
   localparam logic [2:0] OP_AND   = 3'b100;
   localparam logic [2:0] OP_OR    = 3'b101;
   localparam logic [2:0] OP_XOR   = 3'b110;
   localparam logic [2:0] OP_MUL   = 3'b111;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DONE = 2'd2
   } alu_state_t;

endpackage

// File: rtl/alu_seq_mul_iter.sv
// -----------------------------------------------------------------------------
// mul_iter
//   Shift-add unsigned multiplier datapath, one partial product per cycle.
//   Ports:
//     clk, reset : clock, asynchronous active-high reset
//     start      : load A/B, clear accumulator and iteration counter
//     step       : perform one iteration this cycle (held high by the FSM
//                  while it is in MUL)
//     A, B       : multiplicand / multiplier, sampled only on start
//     done       : high in the cycle performing the final (WIDTH-th)
//                  iteration
//     product    : full 2*WIDTH-bit product; valid in the cycle done is high
// -----------------------------------------------------------------------------
module mul_iter #(
   parameter int WIDTH = 64,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic               step,
   input  logic [WIDTH-1:0]   A,
   input  logic [WIDTH-1:0]   B,
   output logic               done,
   output logic [2*WIDTH-1:0] product
);

   logic [2*WIDTH-1:0] acc;
   logic [2*WIDTH-1:0] mcand;
   logic [WIDTH-1:0]   mplier;
   logic [SHW:0]       count;
   logic [2*WIDTH-1:0] acc_next;
   logic [SHW:0]       last_iter;

   assign last_iter = (SHW+1)'(WIDTH - 1);

   // Accumulator value after the iteration happening this cycle. Exposing it
   // as the product lets the owner register the result on the same edge as
   // the last iteration, instead of one cycle later.
   assign acc_next = mplier[0] ? (acc + mcand) : acc;
   assign product  = acc_next;
   assign done     = step && (count == last_iter);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         acc    <= '0;
         mcand  <= '0;
         mplier <= '0;
         count  <= '0;
      end else if (start) begin
         acc    <= '0;
         mcand  <= {{WIDTH{1'b0}}, A};
         mplier <= B;
         count  <= '0;
      end else if (step) begin
         acc    <= acc_next;
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
         count  <= count + 1'b1;
      end
   end

endmodule

// File: rtl/alu_seq.sv
// -----------------------------------------------------------------------------
// alu_seq
//   Registered ALU for the EX stage. Single-cycle ops (pass-B, shift-left,
//   add, sub, and, or, xor) plus an iterative unsigned multiply. Result and
//   flags sit behind a valid/ready handshake.
//
//   Handshake: an op is accepted on a rising edge where in_valid=1 and
//   in_ready=1; in_valid while in_ready=0 is dropped. A result is consumed on
//   a rising edge where out_valid=1 and out_ready=1. The block holds one op
//   at a time, so in_ready and out_valid are never high together.
//
//   Ports:
//     clk, reset            : clock, asynchronous active-high reset
//     in_valid / in_ready   : op request / block idle
//     A, B, cntrl           : operands and operation select
//     out_valid / out_ready : result available / consumer takes it
//     result                : registered result
//     negative, zero        : derived from the registered result
//     overflow, carry_out   : registered flags (add/sub/mul only)
// -----------------------------------------------------------------------------
module alu_seq
   import alu_pkg::*;
#(
   parameter int WIDTH = 64
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [2:0]       cntrl,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             negative,
   output logic             zero,
   output logic             overflow,
   output logic             carry_out
);

   localparam int SHW = $clog2(WIDTH);

   alu_state_t state;

   // Single-cycle datapath
   logic             is_sub;
   logic [WIDTH-1:0] b_eff;
   logic [WIDTH:0]   add_sum;
   logic             msb_carry_in;
   logic [WIDTH-1:0] op_result;
   logic             op_overflow;
   logic             op_carry;

   // Multiplier interface
   logic               mul_start;
   logic               mul_step;
   logic               mul_done;
   logic [2*WIDTH-1:0] mul_product;

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign negative  = result[WIDTH-1];
   assign zero      = (result == '0);

   // Subtraction shares the adder: A + ~B + 1.
   assign is_sub  = (cntrl == OP_SUB);
   assign b_eff   = is_sub ? ~B : B;
   assign add_sum = {1'b0, A} + {1'b0, b_eff} + {{WIDTH{1'b0}}, is_sub};
   // Carry into the MSB recovered from the MSB sum bit and its two inputs.
   assign msb_carry_in = A[WIDTH-1] ^ b_eff[WIDTH-1] ^ add_sum[WIDTH-1];

   always_comb begin
      op_result   = '0;
      op_overflow = 1'b0;
      op_carry    = 1'b0;
      case (cntrl)
         OP_PASSB: op_result = B;
         OP_LSL:   op_result = A << B[SHW-1:0];
         OP_ADD, OP_SUB: begin
            op_result   = add_sum[WIDTH-1:0];
            op_carry    = add_sum[WIDTH];
            op_overflow = add_sum[WIDTH] ^ msb_carry_in;
         end
         OP_AND:   op_result = A & B;
         OP_OR:    op_result = A | B;
         OP_XOR:   op_result = A ^ B;
         OP_MUL:   op_result = '0;
      endcase
   end

   assign mul_start = (state == IDLE) && in_valid && (cntrl == OP_MUL);
   assign mul_step  = (state == MUL);

   mul_iter #(
      .WIDTH (WIDTH),
      .SHW   (SHW)
   ) u_mul (
      .clk     (clk),
      .reset   (reset),
      .start   (mul_start),
      .step    (mul_step),
      .A       (A),
      .B       (B),
      .done    (mul_done),
      .product (mul_product)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         result    <= '0;
         overflow  <= 1'b0;
         carry_out <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  if (cntrl == OP_MUL) begin
                     state <= MUL;
                  end else begin
                     result    <= op_result;
                     overflow  <= op_overflow;
                     carry_out <= op_carry;
                     state     <= DONE;
                  end
               end
            end
            MUL: begin
               // Registered on the edge of the final iteration.
               if (mul_done) begin
                  result    <= mul_product[WIDTH-1:0];
                  overflow  <= |mul_product[2*WIDTH-1:WIDTH];
                  carry_out <= 1'b0;
                  state     <= DONE;
               end
            end
            DONE: begin
               if (out_ready) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_seq.sv
// -----------------------------------------------------------------------------
// tb_alu_seq
//   Directed bench for alu_seq (WIDTH=64 main instance, WIDTH=8 for the
//   narrow shift case). Expected results go into exp_q when an op is issued;
//   a monitor pops and compares whenever a result is consumed.
// -----------------------------------------------------------------------------
module tb_alu_seq;
   import alu_pkg::*;

   localparam int W = 64;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   // ---------------- DUT (WIDTH=64) ----------------
   logic         in_valid, in_ready, out_valid, out_ready;
   logic [W-1:0] A, B, result;
   logic [2:0]   cntrl;
   logic         negative, zero, overflow, carry_out;

   alu_seq #(.WIDTH(W)) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready),
      .A(A), .B(B), .cntrl(cntrl),
      .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .negative(negative), .zero(zero),
      .overflow(overflow), .carry_out(carry_out)
   );

   // ---------------- DUT (WIDTH=8) ----------------
   logic       in_valid8, in_ready8, out_valid8, out_ready8;
   logic [7:0] A8, B8, result8;
   logic [2:0] cntrl8;
   logic       negative8, zero8, overflow8, carry_out8;

   alu_seq #(.WIDTH(8)) dut8 (
      .clk(clk), .reset(reset),
      .in_valid(in_valid8), .in_ready(in_ready8),
      .A(A8), .B(B8), .cntrl(cntrl8),
      .out_valid(out_valid8), .out_ready(out_ready8),
      .result(result8), .negative(negative8), .zero(zero8),
      .overflow(overflow8), .carry_out(carry_out8)
   );

   // ---------------- scoreboard ----------------
   int total = 0;
   int bad   = 0;
   logic [W+3:0] exp_q[$];   // {result, negative, zero, overflow, carry_out}

   task automatic check(input string name, input logic [W+3:0] act, input logic [W+3:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Monitor: a result is consumed on the edge after this negedge.
   always @(negedge clk) begin
      if (!reset && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_result: got %h expected none", result);
         end else begin
            check("result_flags", {result, negative, zero, overflow, carry_out}, exp_q.pop_front());
         end
      end
   end

   // ---------------- driver ----------------
   // Issues one op, queues its expectation and checks latency (cycles from
   // the presentation cycle to the first cycle with out_valid=1).
   task automatic run_op(input string name, input logic [2:0] op,
                         input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] r, input logic n, input logic z,
                         input logic v, input logic c, input int lat);
      int guard;
      int n_cyc;
      @(negedge clk);
      guard = 0;
      while (!in_ready && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      check_int({name, "_ready_wait"}, (guard < 200) ? 1 : 0, 1);
      A        = a;
      B        = b;
      cntrl    = op;
      in_valid = 1'b1;
      exp_q.push_back({r, n, z, v, c});
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      // Operands must not matter after the accept edge.
      A     = '1;
      B     = '1;
      cntrl = OP_ADD;
      n_cyc = 1;
      while (!out_valid && n_cyc < 200) begin
         @(posedge clk);
         #1;
         n_cyc++;
      end
      check_int({name, "_latency"}, n_cyc, lat);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      reset      = 1'b1;
      in_valid   = 1'b0;
      out_ready  = 1'b1;
      A          = '0;
      B          = '0;
      cntrl      = OP_PASSB;
      in_valid8  = 1'b0;
      out_ready8 = 1'b1;
      A8         = '0;
      B8         = '0;
      cntrl8     = OP_PASSB;

      repeat (3) @(negedge clk);
      reset = 1'b0;
      #1;
      // Reset state
      check("reset_state", {result, negative, zero, overflow, carry_out}, {{W{1'b0}}, 4'b0100});
      check_int("reset_in_ready", int'(in_ready), 1);
      check_int("reset_out_valid", int'(out_valid), 0);

      // Adds / subtracts with flag corners
      run_op("add_ovf", OP_ADD, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1,
             64'h8000_0000_0000_0000, 1'b1, 1'b0, 1'b1, 1'b0, 1);
      run_op("sub_eq", OP_SUB, 64'd5, 64'd5, 64'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1);
      run_op("add_wrap", OP_ADD, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1);
      run_op("sub_borrow", OP_SUB, 64'd0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b0, 1);
      run_op("sub_ovf", OP_SUB, 64'h8000_0000_0000_0000, 64'd1,
             64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b1, 1'b1, 1);

      // Logic ops and pass
      run_op("passb", OP_PASSB, 64'h1234, 64'hDEAD, 64'hDEAD, 1'b0, 1'b0, 1'b0, 1'b0, 1);
      run_op("and", OP_AND, 64'hF0F0, 64'hFF00, 64'hF000, 1'b0, 1'b0, 1'b0, 1'b0, 1);
      run_op("or", OP_OR, 64'h0F, 64'hF0, 64'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 1);
      run_op("xor", OP_XOR, 64'hFF, 64'h0F, 64'hF0, 1'b0, 1'b0, 1'b0, 1'b0, 1);

      // Shift uses only B[5:0]
      run_op("lsl", OP_LSL, 64'd1, 64'hFFFF_FFFF_FFFF_FFC3, 64'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1);

      // Narrow instance: shift uses only B[2:0]
      @(negedge clk);
      A8 = 8'h81; B8 = 8'd9; cntrl8 = OP_LSL; in_valid8 = 1'b1;
      @(posedge clk);
      #1;
      in_valid8 = 1'b0;
      check_int("w8_out_valid", int'(out_valid8), 1);
      check("w8_lsl", {{(W-8){1'b0}}, result8, negative8, zero8, overflow8, carry_out8},
            {{(W-8){1'b0}}, 8'h02, 4'b0000});

      // Multiplies
      run_op("mul_55", OP_MUL, 64'd3, 64'h5555_5555_5555_5555,
             64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b0, 65);
      run_op("mul_hi", OP_MUL, 64'h1_0000_0000, 64'h1_0000_0000, 64'd0, 1'b0, 1'b1, 1'b1, 1'b0, 65);
      run_op("mul_small", OP_MUL, 64'd7, 64'd6, 64'd42, 1'b0, 1'b0, 1'b0, 1'b0, 65);

      // Backpressure
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      run_op("bp_or", OP_OR, 64'h12, 64'h30, 64'h32, 1'b0, 1'b0, 1'b0, 1'b0, 1);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         A = 64'd1; B = 64'd1; cntrl = OP_ADD; in_valid = 1'b1;
         #1;
         check("bp_hold", {result, negative, zero, overflow, carry_out}, {64'h32, 4'b0000});
         check_int("bp_in_ready", int'(in_ready), 0);
         check_int("bp_out_valid", int'(out_valid), 1);
      end
      @(posedge clk);
      #1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      check_int("bp_release_out_valid", int'(out_valid), 0);
      check_int("bp_release_in_ready", int'(in_ready), 1);

      // Asynchronous reset in the middle of a multiply
      @(negedge clk);
      A = 64'd3; B = 64'd5; cntrl = OP_MUL; in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (19) @(posedge clk);
      #2;
      check_int("mul_busy_in_ready", int'(in_ready), 0);
      check_int("mul_busy_out_valid", int'(out_valid), 0);
      reset = 1'b1;
      #1;
      check("async_reset", {result, negative, zero, overflow, carry_out}, {{W{1'b0}}, 4'b0100});
      check_int("async_reset_in_ready", int'(in_ready), 1);
      check_int("async_reset_out_valid", int'(out_valid), 0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      run_op("add_after_reset", OP_ADD, 64'd2, 64'd2, 64'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1);

      repeat (3) @(posedge clk);
      check_int("queue_empty", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Global time bound
   initial begin
      #200000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule
